multicycle_controller: RTL
==========================

# multicycle_controller

Sequencing controller for the multicycle MIPS datapath. It replaces per-instruction combinational decode with a Moore/Mealy state machine. The FSM steps one shared ALU and one shared instruction/data memory through fetch, decode, execute, memory and writeback. It also handshakes with a memory that may take several cycles. It sits beside the datapath, consumes the IR opcode/func fields and the ALU zero flag, and drives every mux select and write strobe.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current read/write at this edge
- PCWrite  out  1  load PC
- IRWrite  out  1  load IR (and MDR) from memory
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- Mem2reg  out  1  regfile write data: 0=ALUOut, 1=MDR
- RegDst  out  1  write reg: 0=rt, 1=rd
- RegWrite  out  1  regfile write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- PCSrc  out  1  0=ALU result, 1=ALUOut
- ALUOP  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu
- Sgnzero  out  1  1=sign-extend imm, 0=zero-extend
- illegal  out  1  one-cycle pulse: undefined opcode/func decoded
- state  out  4  current state, for debug

## Operation
- Every output not listed for a state is 0. No x is driven anywhere.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE.
  - Otherwise hold FETCH.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, Sgnzero=1, ALUOP=000. This computes the branch target into ALUOut. Next state:
  - op=0, func=0 (nop) -> FETCH
  - op=0, func in {32..39,42,43} -> EXEC_R
  - op in {8..14} -> EXEC_I
  - op in {35,43} -> ADDR
  - op in {4,5} -> BRANCH
  - anything else -> FETCH with illegal=1
- EXEC_R (2): ALUSrcA=1, ALUSrcB=00, ALUOP from func.
  - add/addu=000, sub/subu=001, and=010, or=011, xor=100, nor=101, slt=110, sltu=111.
  - Next: WB_R.
- WB_R (3): RegDst=1, RegWrite=1, Mem2reg=0. Next: FETCH.
- EXEC_I (4): ALUSrcA=1, ALUSrcB=10.
  - addi/addiu: ALUOP=000, Sgnzero=1.
  - andi/ori/xori: ALUOP=010/011/100, Sgnzero=0.
  - slti/sltiu: ALUOP=110/111, Sgnzero=1.
  - Next: WB_I.
- WB_I (5): RegDst=0, RegWrite=1, Mem2reg=0. Next: FETCH.
- ADDR (6): ALUSrcA=1, ALUSrcB=10, Sgnzero=1, ALUOP=000. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD (7): IorD=1, MemRead=1. Wait for mem_ready, then WB_MEM.
- WB_MEM (8): RegDst=0, RegWrite=1, Mem2reg=1. Next: FETCH.
- MEM_WR (9): IorD=1, MemWrite=1. Wait for mem_ready, then FETCH.
- BRANCH (10): ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCSrc=1.
  - PCWrite = (op==4 & zero) | (op==5 & ~zero).
  - Next: FETCH.
- Codes 11-15 are unreachable. If entered, go to FETCH on the next edge.

## Timing
- State register updates on the rising edge of clk.
- Outputs are combinational from state. IRWrite, PCWrite, illegal and the wait-state exits also depend on the current mem_ready/op/func/zero (Mealy).
- A MemRead or MemWrite request stays asserted, with IorD stable, every cycle until mem_ready is sampled high. The request is then removed in the following state.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Cycles per instruction with mem_ready=1 in the first memory cycle:
  - nop 2, branch 3, R-type 4, I-type 4, sw 4, lw 5.
  - Each extra wait cycle adds 1.
- Reset: rst_n low forces state=FETCH immediately and forces every output to 0, including MemRead. MemRead=1 appears in the first cycle after rst_n rises.
- Reset mid-operation aborts the instruction, with no write strobe after assertion. A pending memory request is dropped.

## Structure
- Package ctrl_pkg holds:
  - the state enum (4-bit, values above)
  - opcode constants (4, 5, 8-14, 35, 43)
  - func constants (32-39, 42, 43)
  - ALUOP encodings
  - ALUSrcB encodings
- Sub-module alu_op_decoder: combinational (op, func) -> (ALUOP, Sgnzero, legal). It is used by the EXEC states and by the DECODE legality check.

## Test plan
- Reset with rst_n=0 and mem_ready=1:
  - Response: all outputs 0 and state=0.
  - After release, MemRead=1, and IRWrite=PCWrite=1 in the same cycle.
- add (op=0, func=32), mem_ready always 1:
  - States 0,1,2,3,0.
  - ALUOP=000 in EXEC_R; RegWrite=1 and RegDst=1 exactly in cycle 4.
- lw (op=35) with mem_ready low for 3 cycles in MEM_RD:
  - MemRead=1 and IorD=1 held for 4 cycles.
  - WB_MEM asserts Mem2reg=1 and RegWrite=1; total 8 cycles.
- beq with zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; beq with zero=0 -> PCWrite=0.
- bne with zero=0 -> PCWrite=1; bne with zero=1 -> PCWrite=0.
- op=63 -> illegal=1 for one cycle in DECODE, then FETCH, with no RegWrite or MemWrite.
- Assert rst_n low during MEM_WR while MemWrite=1 -> MemWrite drops asynchronously and state=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS sequencing controller:
//   - state_e  : 4-bit FSM state encoding (codes 11..15 unused)
//   - OP_* / FN_* : opcode (IR[31:26]) and R-type func (IR[5:0]) values
//   - ALU_*    : ALUOP encodings driven to the shared ALU
//   - SRCB_*   : ALUSrcB mux encodings
//   - ctrl_t   : bundle of every control output, so a state can clear all
//                of them with one assignment and then set only its own
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type func codes
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  // ALUOP encodings
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_src;
    logic [2:0] alu_op;
    logic       sgnzero;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Signal bundle between the sequencing controller and the multicycle
// datapath / memory.
//   master (controller): inputs op, func, zero, mem_ready; drives all mux
//                        selects, write strobes, illegal and state.
//   slave  (datapath)  : the mirror image.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       Mem2reg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCSrc;
  logic [2:0] ALUOP;
  logic       Sgnzero;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, func, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2reg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOP, Sgnzero, illegal, state
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2reg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOP, Sgnzero, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Combinational instruction classifier.
//   op, func : IR opcode and func fields
//   aluop    : ALU operation for the EXEC states
//   sgnzero  : 1 = sign-extend immediate, 0 = zero-extend (I-type only)
//   legal    : instruction is one the controller implements (nop excluded;
//              the controller recognises it separately)
// ---------------------------------------------------------------------------
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [2:0] aluop,
  output logic       sgnzero,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    aluop   = ALU_ADD;
    sgnzero = 1'b0;
    legal   = 1'b0;
    if (op == OP_RTYPE) begin
      legal = 1'b1;
      case (func)
        FN_ADD, FN_ADDU: aluop = ALU_ADD;
        FN_SUB, FN_SUBU: aluop = ALU_SUB;
        FN_AND:          aluop = ALU_AND;
        FN_OR:           aluop = ALU_OR;
        FN_XOR:          aluop = ALU_XOR;
        FN_NOR:          aluop = ALU_NOR;
        FN_SLT:          aluop = ALU_SLT;
        FN_SLTU:         aluop = ALU_SLTU;
        default:         legal = 1'b0;
      endcase
    end else begin
      legal   = 1'b1;
      sgnzero = 1'b1;
      case (op)
        OP_ADDI, OP_ADDIU: aluop = ALU_ADD;
        OP_SLTI:           aluop = ALU_SLT;
        OP_SLTIU:          aluop = ALU_SLTU;
        // Logical immediates are zero-extended.
        OP_ANDI: begin aluop = ALU_AND; sgnzero = 1'b0; end
        OP_ORI:  begin aluop = ALU_OR;  sgnzero = 1'b0; end
        OP_XORI: begin aluop = ALU_XOR; sgnzero = 1'b0; end
        OP_LW, OP_SW:      aluop = ALU_ADD;
        OP_BEQ, OP_BNE:    aluop = ALU_SUB;
        default: begin
          legal   = 1'b0;
          sgnzero = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// FSM sequencing a multicycle MIPS datapath through fetch, decode, execute,
// memory and writeback, with a wait-state handshake on the shared memory.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; also forces every output to 0
//   bus   : master side of multicycle_controller_if (IR fields, ALU zero,
//           mem_ready in; mux selects, strobes, illegal, state out)
// Outputs are decoded from the state register; IRWrite/PCWrite in FETCH,
// illegal in DECODE and PCWrite in BRANCH also look at the live inputs.
// ---------------------------------------------------------------------------
module multicycle_controller
  import ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e     state_q;
  ctrl_t      ctl;
  logic [2:0] dec_aluop;
  logic       dec_sgnzero;
  logic       dec_legal;
  logic       is_nop;
  logic       is_mem;
  logic       is_branch;

  alu_op_decoder u_alu_op_decoder (
    .op      (bus.op),
    .func    (bus.func),
    .aluop   (dec_aluop),
    .sgnzero (dec_sgnzero),
    .legal   (dec_legal)
  );

  assign is_nop    = (bus.op == OP_RTYPE) && (bus.func == 6'd0);
  assign is_mem    = (bus.op == OP_LW) || (bus.op == OP_SW);
  assign is_branch = (bus.op == OP_BEQ) || (bus.op == OP_BNE);

  // NOTE: state is sequential, so it is written only with non-blocking
  // assignments; the combinational decode below uses blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (is_nop || !dec_legal)   state_q <= S_FETCH;
          else if (bus.op == OP_RTYPE) state_q <= S_EXEC_R;
          else if (is_mem)            state_q <= S_ADDR;
          else if (is_branch)         state_q <= S_BRANCH;
          else                        state_q <= S_EXEC_I;
        end
        S_EXEC_R: state_q <= S_WB_R;
        S_WB_R:   state_q <= S_FETCH;
        S_EXEC_I: state_q <= S_WB_I;
        S_WB_I:   state_q <= S_FETCH;
        S_ADDR:   state_q <= (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (bus.mem_ready) state_q <= S_WB_MEM;
        S_WB_MEM: state_q <= S_FETCH;
        S_MEM_WR: if (bus.mem_ready) state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        // Unused codes recover to FETCH.
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    // Outputs are gated by rst_n directly: FETCH is state 0 and would
    // otherwise raise MemRead while reset is still held.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = SRCB_FOUR;
          ctl.alu_op    = ALU_ADD;
          ctl.ir_write  = bus.mem_ready;
          ctl.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          // Branch target PC + (sext(imm) << 2) lands in ALUOut.
          ctl.alu_src_b = SRCB_IMM_SH;
          ctl.sgnzero   = 1'b1;
          ctl.alu_op    = ALU_ADD;
          ctl.illegal   = !is_nop && !dec_legal;
        end
        S_EXEC_R: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_RT;
          ctl.alu_op    = dec_aluop;
        end
        S_WB_R: begin
          ctl.reg_dst   = 1'b1;
          ctl.reg_write = 1'b1;
        end
        S_EXEC_I: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_IMM;
          ctl.alu_op    = dec_aluop;
          ctl.sgnzero   = dec_sgnzero;
        end
        S_WB_I: ctl.reg_write = 1'b1;
        S_ADDR: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_IMM;
          ctl.sgnzero   = 1'b1;
          ctl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          ctl.iord     = 1'b1;
          ctl.mem_read = 1'b1;
        end
        S_WB_MEM: begin
          ctl.reg_write = 1'b1;
          ctl.mem2reg   = 1'b1;
        end
        S_MEM_WR: begin
          ctl.iord      = 1'b1;
          ctl.mem_write = 1'b1;
        end
        S_BRANCH: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_RT;
          ctl.alu_op    = ALU_SUB;
          ctl.pc_src    = 1'b1;
          ctl.pc_write  = ((bus.op == OP_BEQ) &&  bus.zero) ||
                          ((bus.op == OP_BNE) && !bus.zero);
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite  = ctl.pc_write;
  assign bus.IRWrite  = ctl.ir_write;
  assign bus.IorD     = ctl.iord;
  assign bus.MemRead  = ctl.mem_read;
  assign bus.MemWrite = ctl.mem_write;
  assign bus.Mem2reg  = ctl.mem2reg;
  assign bus.RegDst   = ctl.reg_dst;
  assign bus.RegWrite = ctl.reg_write;
  assign bus.ALUSrcA  = ctl.alu_src_a;
  assign bus.ALUSrcB  = ctl.alu_src_b;
  assign bus.PCSrc    = ctl.pc_src;
  assign bus.ALUOP    = ctl.alu_op;
  assign bus.Sgnzero  = ctl.sgnzero;
  assign bus.illegal  = ctl.illegal;
  assign bus.state    = state_q;

endmodule
